// File: rtl/reg_sched_pkg.sv
// Shared types and constants for the round-robin scheduled register block.
package reg_sched_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    ADD     = 2'd1,
    SUB_ODD = 2'd2,
    READ    = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned SUB_ODD_DELTA = 7;

endpackage

// File: rtl/reg_sched_arbiter.sv
// Combinational round-robin arbiter: first valid request after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    // Search offsets 1..N so last_grant itself is visited last.
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last_grant) + i) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_sched.sv
// Shared register updated by NUM_REQ requesters through an IDLE/EXEC/RESP scheduler.
module reg_sched
  import reg_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][1:0]       req_op,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]              rsp_data,
  output logic [WIDTH-1:0]              my_reg,
  output logic [15:0]                   ops_done
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_t            state, state_nxt;
  opcode_t           op_q;
  logic [WIDTH-1:0]  data_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_id;
  logic              any_req;
  logic              accept;
  logic              done;
  logic [WIDTH-1:0]  reg_nxt;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id),
    .any        (any_req)
  );

  assign accept = (state == IDLE) && any_req;
  assign done   = (state == RESP) && rsp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    reg_nxt = my_reg;
    unique case (op_q)
      LOAD:    reg_nxt = data_q;
      ADD:     reg_nxt = my_reg + data_q;
      SUB_ODD: if (my_reg[0]) reg_nxt = my_reg - WIDTH'(SUB_ODD_DELTA);
      default: reg_nxt = my_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      my_reg     <= '0;
      ops_done   <= '0;
      op_q       <= READ;
      data_q     <= '0;
      id_q       <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        op_q   <= opcode_t'(req_op[grant_id]);
        data_q <= req_data[grant_id];
        id_q   <= grant_id;
      end
      if (state == EXEC) my_reg <= reg_nxt;
      if (done) begin
        last_grant <= id_q;
        ops_done   <= ops_done + 16'd1;
      end
    end
  end

  // my_reg is frozen in RESP, so it doubles as the stable response payload.
  assign req_ready = (state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = my_reg;

endmodule

// File: tb/tb_reg_sched.sv
// Scoreboard bench for reg_sched: expected responses queued at grant, checked on rsp_valid.
module tb_reg_sched;
  import reg_sched_pkg::*;

  logic            clock;
  logic            reset_n;
  logic [3:0]      req_valid;
  logic [3:0][1:0] req_op;
  logic [3:0][7:0] req_data;
  logic [3:0]      req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_data;
  logic [7:0]      my_reg;
  logic [15:0]     ops_done;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         vectors;
  int         miscompares;
  logic [7:0] model_reg;
  int         model_last;
  int         model_ops;

  reg_sched #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .my_reg    (my_reg),
    .ops_done  (ops_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_apply(input opcode_t op, input logic [7:0] r,
                                             input logic [7:0] d);
    case (op)
      LOAD:    return d;
      ADD:     return r + d;
      SUB_ODD: return r[0] ? r - 8'd7 : r;
      default: return r;
    endcase
  endfunction

  task automatic reset_dut();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n    = 1'b1;
    model_reg  = '0;
    model_last = 3;
    model_ops  = 0;
    sb.delete();
  endtask

  // Drives one requester alone until granted; returns at the negedge in EXEC.
  task automatic run_op(input int id, input opcode_t op, input logic [7:0] d);
    int n;
    logic [3:0] onehot;
    onehot        = 4'(1 << id);
    req_valid     = onehot;
    req_op[id]    = op;
    req_data[id]  = d;
    #1;
    n = 0;
    while (req_ready === 4'b0000 && n < 8) begin
      @(negedge clock);
      #1;
      n++;
    end
    vectors++;
    if (req_ready !== onehot) begin
      miscompares++;
      $display("FAIL grant_req%0d: got %b, expected %b", id, req_ready, onehot);
    end else begin
      model_reg  = model_apply(op, model_reg, d);
      model_last = id;
      sb.push_back('{id: 2'(id), data: model_reg});
    end
    @(negedge clock);
    req_valid = '0;
  endtask

  task automatic wait_rsp(output bit got);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    got = (rsp_valid === 1'b1);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rsp_timeout: got rsp_valid=%b, expected 1", rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    #12;
    vectors += 6;
    if (my_reg !== 8'd0)    begin miscompares++; $display("FAIL rst_my_reg: got %0h, expected 0", my_reg); end
    if (ops_done !== 16'd0) begin miscompares++; $display("FAIL rst_ops_done: got %0h, expected 0", ops_done); end
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b, expected 0", rsp_valid); end
    if (rsp_id !== 2'd0)    begin miscompares++; $display("FAIL rst_rsp_id: got %0d, expected 0", rsp_id); end
    if (rsp_data !== 8'd0)  begin miscompares++; $display("FAIL rst_rsp_data: got %0h, expected 0", rsp_data); end
    if (req_ready !== 4'd0) begin miscompares++; $display("FAIL rst_req_ready: got %b, expected 0000", req_ready); end
    reset_dut();
  endtask

  task automatic test_load();
    exp_t e;
    run_op(0, LOAD, 8'd5);
    vectors += 2;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL load_early_rsp: got %b, expected 0", rsp_valid); end
    if (req_ready !== 4'd0) begin miscompares++; $display("FAIL load_exec_ready: got %b, expected 0000", req_ready); end
    @(negedge clock);
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL load_latency: got rsp_valid=%b, expected 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      vectors += 2;
      if (rsp_id !== e.id)     begin miscompares++; $display("FAIL load_rsp_id: got %0d, expected %0d", rsp_id, e.id); end
      if (rsp_data !== e.data) begin miscompares++; $display("FAIL load_rsp_data: got %0d, expected %0d", rsp_data, e.data); end
      model_ops++;
    end
    @(negedge clock);
    vectors += 2;
    if (ops_done !== 16'(model_ops)) begin miscompares++; $display("FAIL load_ops_done: got %0d, expected %0d", ops_done, model_ops); end
    if (my_reg !== 8'd5) begin miscompares++; $display("FAIL load_my_reg: got %0d, expected 5", my_reg); end
  endtask

  task automatic test_sub_odd();
    exp_t e;
    bit got;
    for (int unsigned k = 0; k < 2; k++) begin
      run_op(int'(k) + 1, SUB_ODD, 8'd0);
      wait_rsp(got);
      if (got && sb.size() > 0) begin
        e = sb.pop_front();
        vectors += 3;
        if (rsp_id !== e.id)     begin miscompares++; $display("FAIL sub_odd%0d_id: got %0d, expected %0d", k, rsp_id, e.id); end
        if (rsp_data !== e.data) begin miscompares++; $display("FAIL sub_odd%0d_data: got %0d, expected %0d", k, rsp_data, e.data); end
        if (rsp_data !== 8'd254) begin miscompares++; $display("FAIL sub_odd%0d_abs: got %0d, expected 254", k, rsp_data); end
        model_ops++;
      end
      @(negedge clock);
    end
    vectors++;
    if (ops_done !== 16'(model_ops)) begin miscompares++; $display("FAIL sub_odd_ops_done: got %0d, expected %0d", ops_done, model_ops); end
  endtask

  task automatic test_add_wrap();
    exp_t e;
    bit got;
    run_op(3, LOAD, 8'd250);
    wait_rsp(got);
    if (got) begin void'(sb.pop_front()); model_ops++; end
    @(negedge clock);
    run_op(0, ADD, 8'd10);
    wait_rsp(got);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      vectors += 3;
      if (rsp_id !== e.id)     begin miscompares++; $display("FAIL add_wrap_id: got %0d, expected %0d", rsp_id, e.id); end
      if (rsp_data !== e.data) begin miscompares++; $display("FAIL add_wrap_data: got %0d, expected %0d", rsp_data, e.data); end
      if (rsp_data !== 8'd4)   begin miscompares++; $display("FAIL add_wrap_abs: got %0d, expected 4", rsp_data); end
      model_ops++;
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n_acc, n_rsp, cyc, last_acc, exp_id;
    reset_dut();
    req_op    = {READ, READ, READ, READ};
    req_valid = 4'hF;
    n_acc = 0; n_rsp = 0; cyc = 0; last_acc = 0;
    while (n_rsp < 5 && cyc < 40) begin
      #1;
      if (req_ready !== 4'b0000) begin
        exp_id = (model_last + 1) % 4;
        vectors++;
        if (req_ready !== 4'(1 << exp_id)) begin
          miscompares++;
          $display("FAIL rr_grant%0d: got %b, expected %b", n_acc, req_ready, 4'(1 << exp_id));
        end
        if (n_acc > 0) begin
          vectors++;
          if (cyc - last_acc != 3) begin
            miscompares++;
            $display("FAIL rr_spacing%0d: got %0d cycles, expected 3", n_acc, cyc - last_acc);
          end
        end
        sb.push_back('{id: 2'(exp_id), data: model_reg});
        model_last = exp_id;
        last_acc   = cyc;
        n_acc++;
      end
      if (rsp_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        vectors += 2;
        if (rsp_id !== e.id)     begin miscompares++; $display("FAIL rr_rsp%0d_id: got %0d, expected %0d", n_rsp, rsp_id, e.id); end
        if (rsp_data !== e.data) begin miscompares++; $display("FAIL rr_rsp%0d_data: got %0d, expected %0d", n_rsp, rsp_data, e.data); end
        model_ops++;
        n_rsp++;
        if (n_rsp == 5) req_valid = '0;
      end
      @(negedge clock);
      cyc++;
    end
    vectors += 2;
    if (n_rsp != 5) begin miscompares++; $display("FAIL rr_count: got %0d responses, expected 5", n_rsp); end
    if (ops_done !== 16'(model_ops)) begin miscompares++; $display("FAIL rr_ops_done: got %0d, expected %0d", ops_done, model_ops); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int exp_id;
    rsp_ready = 1'b0;
    req_op    = {LOAD, LOAD, LOAD, LOAD};
    req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
    req_valid = 4'hF;
    #1;
    exp_id = (model_last + 1) % 4;
    vectors++;
    if (req_ready !== 4'(1 << exp_id)) begin
      miscompares++;
      $display("FAIL bp_grant: got %b, expected %b", req_ready, 4'(1 << exp_id));
    end
    model_reg  = 8'h30 + 8'(exp_id);
    model_last = exp_id;
    sb.push_back('{id: 2'(exp_id), data: model_reg});
    repeat (2) @(negedge clock);
    e = sb.pop_front();
    for (int unsigned k = 0; k < 5; k++) begin
      vectors += 4;
      if (rsp_valid !== 1'b1)  begin miscompares++; $display("FAIL bp_valid%0d: got %b, expected 1", k, rsp_valid); end
      if (rsp_id !== e.id)     begin miscompares++; $display("FAIL bp_id%0d: got %0d, expected %0d", k, rsp_id, e.id); end
      if (rsp_data !== e.data) begin miscompares++; $display("FAIL bp_data%0d: got %0h, expected %0h", k, rsp_data, e.data); end
      if (req_ready !== 4'd0)  begin miscompares++; $display("FAIL bp_ready%0d: got %b, expected 0000", k, req_ready); end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    model_ops++;
    @(negedge clock);
    vectors += 2;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b, expected 0", rsp_valid); end
    if (ops_done !== 16'(model_ops)) begin miscompares++; $display("FAIL bp_ops_done: got %0d, expected %0d", ops_done, model_ops); end
  endtask

  task automatic test_reset_abort();
    int seen;
    req_op[2]   = LOAD;
    req_data[2] = 8'd9;
    req_valid   = 4'b0100;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL abort_grant: got %b, expected 0100", req_ready); end
    @(negedge clock);
    req_valid = '0;
    reset_n   = 1'b0;
    #1;
    vectors += 3;
    if (my_reg !== 8'd0)    begin miscompares++; $display("FAIL abort_my_reg: got %0h, expected 0", my_reg); end
    if (ops_done !== 16'd0) begin miscompares++; $display("FAIL abort_ops_done: got %0d, expected 0", ops_done); end
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_rsp_valid: got %b, expected 0", rsp_valid); end
    #1;
    reset_n    = 1'b1;
    model_reg  = '0;
    model_last = 3;
    model_ops  = 0;
    seen = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0) seen++;
    end
    vectors += 3;
    if (seen != 0)          begin miscompares++; $display("FAIL abort_no_rsp: got %0d rsp cycles, expected 0", seen); end
    if (my_reg !== 8'd0)    begin miscompares++; $display("FAIL abort_reg_after: got %0h, expected 0", my_reg); end
    if (ops_done !== 16'd0) begin miscompares++; $display("FAIL abort_ops_after: got %0d, expected 0", ops_done); end
    req_op    = {READ, READ, READ, READ};
    req_valid = 4'hF;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL abort_next_grant: got %b, expected 0001", req_ready); end
    req_valid = '0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_load();
    test_sub_odd();
    test_add_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
